// File: rtl/lc3_fetch_pkg.sv
// Shared definitions for the LC3 instruction prefetch path: FSM encoding,
// default widths, reset fetch address and the queue entry layout.
package lc3_fetch_pkg;

    localparam int LC3_ADDR_W = 16;
    localparam int LC3_DATA_W = 16;
    localparam logic [LC3_ADDR_W-1:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SQUASH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [LC3_DATA_W-1:0] instr;
        logic [LC3_ADDR_W-1:0] pc;
        logic [LC3_ADDR_W-1:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/lc3_sync_fifo.sv
// Single-clock FIFO with a combinational head read and a synchronous flush
// that takes priority over any push or pop in the same cycle.
module lc3_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; count gates validity, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lc3_prefetch_queue.sv
// LC3 instruction prefetch stage: issues one outstanding instruction read at a
// time, buffers fetched words with pc/npc for Decode, and flushes on redirect.
module lc3_prefetch_queue
    import lc3_fetch_pkg::*;
#(
    parameter int                ADDR_W   = LC3_ADDR_W,
    parameter int                DATA_W   = LC3_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LC3_RESET_PC)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable_fetch,
    input  logic                        br_taken,
    input  logic [ADDR_W-1:0]           taddr,
    output logic [ADDR_W-1:0]           pc,
    output logic                        instrmem_rd,
    input  logic [DATA_W-1:0]           Instr_dout,
    input  logic                        complete_instr,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [DATA_W-1:0]           dec_instr,
    output logic [ADDR_W-1:0]           dec_pc,
    output logic [ADDR_W-1:0]           dec_npc,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DATA_W + 2 * ADDR_W;

    fetch_state_e       state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   count;
    logic [ENT_W-1:0]   head_word;
    logic [1:0]         rst_pipe;
    logic               rst_n;
    logic               do_push;
    logic               do_pop;
    logic               has_space;
    logic               room_after_push;

    // NOTE: reset asserts asynchronously but releases through two flops so no state leaves reset mid-cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    assign dec_valid = (count != '0) && !br_taken;
    assign do_pop    = dec_valid && dec_ready;
    assign do_push   = (state == ST_WAIT) && complete_instr && !br_taken;
    assign has_space = count < CNT_W'(DEPTH);
    // A same-cycle pop frees the slot this push would otherwise fill last.
    assign room_after_push = (count < CNT_W'(DEPTH - 1)) || do_pop;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            instrmem_rd <= 1'b0;
        end else begin
            if (br_taken)     fetch_pc <= taddr;
            else if (do_push) fetch_pc <= fetch_pc + ADDR_W'(1);

            case (state)
                ST_IDLE: begin
                    if (enable_fetch && !br_taken && has_space) begin
                        state       <= ST_WAIT;
                        instrmem_rd <= 1'b1;
                        pc          <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (br_taken) begin
                        if (complete_instr) begin
                            state       <= ST_IDLE;
                            instrmem_rd <= 1'b0;
                        end else begin
                            state <= ST_SQUASH;
                        end
                    end else if (complete_instr) begin
                        if (enable_fetch && room_after_push) begin
                            pc <= fetch_pc + ADDR_W'(1);
                        end else begin
                            state       <= ST_IDLE;
                            instrmem_rd <= 1'b0;
                        end
                    end
                end
                ST_SQUASH: begin
                    // The stale read must finish on the bus before a new one can go out.
                    if (complete_instr) begin
                        state       <= ST_IDLE;
                        instrmem_rd <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instrmem_rd <= 1'b0;
                end
            endcase
        end
    end

    lc3_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (rst_n),
        .push    (do_push),
        .pop     (do_pop),
        .flush   (br_taken),
        .wr_data ({Instr_dout, fetch_pc, fetch_pc + ADDR_W'(1)}),
        .rd_data (head_word),
        .count   (count)
    );

    assign {dec_instr, dec_pc, dec_npc} = head_word;
    assign occupancy = count;

endmodule

// File: tb/tb_lc3_prefetch_queue.sv
// Directed bench for lc3_prefetch_queue: inputs are driven and outputs
// sampled on the falling clock edge; memory is modelled inline by mem_read.
module tb_lc3_prefetch_queue;
    import lc3_fetch_pkg::*;

    logic        clock;
    logic        reset;
    logic        enable_fetch;
    logic        br_taken;
    logic [15:0] taddr;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [15:0] dec_npc;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t drain_exp [4];

    lc3_prefetch_queue #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (4),
        .RESET_PC (16'h3000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable_fetch   (enable_fetch),
        .br_taken       (br_taken),
        .taddr          (taddr),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_npc        (dec_npc),
        .occupancy      (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Internal reset release takes two edges; one more lets the FSM see a live edge.
    task automatic do_reset(input logic en);
        reset          = 1'b0;
        enable_fetch   = 1'b0;
        br_taken       = 1'b0;
        taddr          = '0;
        Instr_dout     = '0;
        complete_instr = 1'b0;
        dec_ready      = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        step();
        enable_fetch = en;
    endtask

    task automatic wait_rd(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (instrmem_rd === 1'b1) break;
            step();
        end
        check({tag, " request seen"}, instrmem_rd, 1);
    endtask

    // Entered in the first cycle of a request; completes it in the second cycle.
    task automatic mem_read(input string tag, input logic [15:0] exp_pc,
                            input logic [15:0] data, input logic pop_with);
        check({tag, " rd"}, instrmem_rd, 1);
        check({tag, " pc"}, pc, exp_pc);
        step();
        check({tag, " pc held"}, pc, exp_pc);
        complete_instr = 1'b1;
        Instr_dout     = data;
        if (pop_with) dec_ready = 1'b1;
        step();
        complete_instr = 1'b0;
        Instr_dout     = '0;
        if (pop_with) dec_ready = 1'b0;
    endtask

    initial begin
        drain_exp[0] = '{instr: 16'hA002, pc: 16'hFFFF, npc: 16'h0000};
        drain_exp[1] = '{instr: 16'hA003, pc: 16'h0000, npc: 16'h0001};
        drain_exp[2] = '{instr: 16'hA004, pc: 16'h0001, npc: 16'h0002};
        drain_exp[3] = '{instr: 16'hA005, pc: 16'h0002, npc: 16'h0003};

        // 1: streaming fetch with Decode always ready
        do_reset(1'b0);
        check("t1 reset occupancy", occupancy, 0);
        check("t1 reset dec_valid", dec_valid, 0);
        check("t1 reset rd", instrmem_rd, 0);
        check("t1 reset pc", pc, 16'h3000);
        enable_fetch = 1'b1;
        dec_ready    = 1'b1;
        wait_rd("t1");
        mem_read("t1 r0", 16'h3000, 16'h1111, 1'b0);
        check("t1 head valid", dec_valid, 1);
        check("t1 occupancy", occupancy, 1);
        check("t1 dec_pc 0", dec_pc, 16'h3000);
        check("t1 dec_npc 0", dec_npc, 16'h3001);
        check("t1 dec_instr 0", dec_instr, 16'h1111);
        mem_read("t1 r1", 16'h3001, 16'h2222, 1'b0);
        check("t1 dec_pc 1", dec_pc, 16'h3001);
        check("t1 dec_instr 1", dec_instr, 16'h2222);
        mem_read("t1 r2", 16'h3002, 16'h3333, 1'b0);
        check("t1 dec_pc 2", dec_pc, 16'h3002);
        check("t1 dec_npc 2", dec_npc, 16'h3003);

        // 2: Decode stalled fills the queue, one pop releases one read
        do_reset(1'b1);
        wait_rd("t2");
        mem_read("t2 r0", 16'h3000, 16'h0A00, 1'b0);
        mem_read("t2 r1", 16'h3001, 16'h0A01, 1'b0);
        mem_read("t2 r2", 16'h3002, 16'h0A02, 1'b0);
        mem_read("t2 r3", 16'h3003, 16'h0A03, 1'b0);
        check("t2 full occupancy", occupancy, 4);
        check("t2 full rd", instrmem_rd, 0);
        step();
        step();
        step();
        check("t2 full rd stays low", instrmem_rd, 0);
        check("t2 full head pc", dec_pc, 16'h3000);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("t2 after pop occupancy", occupancy, 3);
        check("t2 after pop head", dec_pc, 16'h3001);
        check("t2 after pop rd", instrmem_rd, 0);
        step();
        mem_read("t2 r4", 16'h3004, 16'h0A04, 1'b0);
        check("t2 refill occupancy", occupancy, 4);

        // 3: redirect while a read is outstanding
        do_reset(1'b1);
        dec_ready = 1'b1;
        wait_rd("t3");
        check("t3 first pc", pc, 16'h3000);
        br_taken = 1'b1;
        taddr    = 16'h4000;
        step();
        br_taken = 1'b0;
        taddr    = '0;
        check("t3 squash rd", instrmem_rd, 1);
        check("t3 squash pc", pc, 16'h3000);
        step();
        check("t3 squash rd held", instrmem_rd, 1);
        check("t3 squash pc held", pc, 16'h3000);
        complete_instr = 1'b1;
        Instr_dout     = 16'hDEAD;
        step();
        complete_instr = 1'b0;
        Instr_dout     = '0;
        check("t3 post squash rd", instrmem_rd, 0);
        check("t3 post squash occupancy", occupancy, 0);
        check("t3 post squash dec_valid", dec_valid, 0);
        step();
        mem_read("t3 r0", 16'h4000, 16'hABCD, 1'b0);
        check("t3 dec_pc", dec_pc, 16'h4000);
        check("t3 dec_npc", dec_npc, 16'h4001);
        check("t3 dec_instr", dec_instr, 16'hABCD);

        // 4: redirect coincident with completion and a pop request
        dec_ready = 1'b0;
        step();
        check("t4 pre occupancy", occupancy, 1);
        complete_instr = 1'b1;
        Instr_dout     = 16'h1234;
        br_taken       = 1'b1;
        taddr          = 16'h5000;
        dec_ready      = 1'b1;
        #1;
        check("t4 dec_valid masked", dec_valid, 0);
        step();
        complete_instr = 1'b0;
        Instr_dout     = '0;
        br_taken       = 1'b0;
        taddr          = '0;
        dec_ready      = 1'b0;
        check("t4 occupancy", occupancy, 0);
        check("t4 rd", instrmem_rd, 0);
        check("t4 dec_valid", dec_valid, 0);
        step();
        check("t4 redirect rd", instrmem_rd, 1);
        check("t4 redirect pc", pc, 16'h5000);

        // 5: pc wrap, push+pop at DEPTH-1, then full queue drained in order
        do_reset(1'b0);
        br_taken = 1'b1;
        taddr    = 16'hFFFE;
        step();
        br_taken     = 1'b0;
        taddr        = '0;
        enable_fetch = 1'b1;
        wait_rd("t5");
        mem_read("t5 r0", 16'hFFFE, 16'hA001, 1'b0);
        mem_read("t5 r1", 16'hFFFF, 16'hA002, 1'b0);
        mem_read("t5 r2", 16'h0000, 16'hA003, 1'b0);
        mem_read("t5 r3", 16'h0001, 16'hA004, 1'b1);
        check("t5 push+pop occupancy", occupancy, 3);
        check("t5 wrap head pc", dec_pc, 16'hFFFF);
        check("t5 wrap head npc", dec_npc, 16'h0000);
        check("t5 wrap head instr", dec_instr, 16'hA002);
        mem_read("t5 r4", 16'h0002, 16'hA005, 1'b0);
        check("t5 full occupancy", occupancy, 4);
        check("t5 full rd", instrmem_rd, 0);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5 drain %0d pc", i), dec_pc, drain_exp[i].pc);
            check($sformatf("t5 drain %0d npc", i), dec_npc, drain_exp[i].npc);
            check($sformatf("t5 drain %0d instr", i), dec_instr, drain_exp[i].instr);
            step();
        end
        dec_ready = 1'b0;
        check("t5 drained occupancy", occupancy, 0);
        check("t5 drained dec_valid", dec_valid, 0);
        check("t5 next rd", instrmem_rd, 1);
        check("t5 next pc", pc, 16'h0003);

        // 6: asynchronous reset in the middle of an outstanding read
        reset = 1'b0;
        #1;
        check("t6 async rd", instrmem_rd, 0);
        check("t6 async dec_valid", dec_valid, 0);
        check("t6 async occupancy", occupancy, 0);
        enable_fetch = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        step();
        check("t6 release pc", pc, 16'h3000);
        check("t6 release rd", instrmem_rd, 0);
        complete_instr = 1'b1;
        Instr_dout     = 16'hBEEF;
        step();
        complete_instr = 1'b0;
        Instr_dout     = '0;
        check("t6 stale occupancy", occupancy, 0);
        check("t6 stale dec_valid", dec_valid, 0);
        check("t6 stale rd", instrmem_rd, 0);
        enable_fetch = 1'b1;
        wait_rd("t6");
        check("t6 first pc", pc, 16'h3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
